// File: rtl/ball_game_controller.sv
// Per-frame game sequencer: owns ball position/velocity, score and game state,
// and turns per-frame object-pixel counts inside the ball area into bounces.
module ball_game_controller #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 20,
    parameter int INIT_SPEED   = 2,
    parameter int MAX_SPEED    = 7,
    parameter int HIT_THRESH   = 40,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       pixel_valid,
    input  logic       is_hit_area,
    input  logic       obj_pixel,
    input  logic       start_btn,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic       hit_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    localparam logic [9:0]         X_CENTRE   = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]         Y_CENTRE   = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]         X_MAX      = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] X_MAX_S    = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX_S    = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [3:0]  SPEED0     = 4'(INIT_SPEED);
    localparam logic signed [3:0]  SPEED_CAP  = 4'(MAX_SPEED);
    localparam logic [8:0]         HIT_MIN    = 9'(HIT_THRESH);
    localparam logic [8:0]         HIT_SAT    = 9'h1FF;
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);

    state_t             state_reg;
    logic [9:0]         ball_x_reg;
    logic [9:0]         ball_y_reg;
    logic signed [3:0]  vx_reg;
    logic signed [3:0]  vy_reg;
    logic [7:0]         score_reg;
    logic               hit_flag_reg;
    logic [8:0]         hit_cnt_reg;
    logic [7:0]         serve_cnt_reg;
    logic               start_prev_reg;
    // Sign of the most recent serve; starts "positive" so the first serve goes left.
    logic               serve_pos_reg;

    logic               start_edge;
    logic               pix_qual;
    logic               hit_now;
    logic signed [3:0]  vy_cap;
    logic signed [3:0]  vy_post;
    logic signed [10:0] nx;
    logic signed [10:0] ny;

    assign start_edge = start_btn & ~start_prev_reg;
    assign pix_qual   = pixel_valid & is_hit_area & obj_pixel;

    always_comb begin
        hit_now = (hit_cnt_reg >= HIT_MIN) && (vy_reg > 4'sd0);
        // vy is positive whenever a hit can apply, so +1 below the cap cannot overflow.
        vy_cap  = (vy_reg >= SPEED_CAP) ? SPEED_CAP : (vy_reg + 4'sd1);
        vy_post = hit_now ? -vy_cap : vy_reg;
        nx      = $signed({1'b0, ball_x_reg}) + {{7{vx_reg[3]}}, vx_reg};
        ny      = $signed({1'b0, ball_y_reg}) + {{7{vy_post[3]}}, vy_post};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            ball_x_reg     <= X_CENTRE;
            ball_y_reg     <= Y_CENTRE;
            vx_reg         <= SPEED0;
            vy_reg         <= SPEED0;
            score_reg      <= 8'd0;
            hit_flag_reg   <= 1'b0;
            hit_cnt_reg    <= 9'd0;
            serve_cnt_reg  <= 8'd0;
            start_prev_reg <= 1'b0;
            serve_pos_reg  <= 1'b1;
        end else begin
            start_prev_reg <= start_btn;
            hit_flag_reg   <= 1'b0;

            // A qualifying pixel in the frame_tick cycle itself is dropped.
            if (frame_tick) begin
                hit_cnt_reg <= 9'd0;
            end else if (pix_qual && (hit_cnt_reg != HIT_SAT)) begin
                hit_cnt_reg <= hit_cnt_reg + 9'd1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_reg     <= ST_SERVE;
                        ball_x_reg    <= X_CENTRE;
                        ball_y_reg    <= Y_CENTRE;
                        score_reg     <= 8'd0;
                        serve_cnt_reg <= 8'd0;
                        vy_reg        <= SPEED0;
                        vx_reg        <= serve_pos_reg ? -SPEED0 : SPEED0;
                        serve_pos_reg <= ~serve_pos_reg;
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt_reg == SERVE_LAST) begin
                            state_reg <= ST_PLAY;
                        end else begin
                            serve_cnt_reg <= serve_cnt_reg + 8'd1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (frame_tick) begin
                        if (hit_now) begin
                            hit_flag_reg <= 1'b1;
                            if (score_reg != 8'hFF) begin
                                score_reg <= score_reg + 8'd1;
                            end
                        end

                        if (nx[10]) begin
                            ball_x_reg <= 10'd0;
                            vx_reg     <= -vx_reg;
                        end else if (nx > X_MAX_S) begin
                            ball_x_reg <= X_MAX;
                            vx_reg     <= -vx_reg;
                        end else begin
                            ball_x_reg <= nx[9:0];
                        end

                        // A hit this frame overrides leaving through the bottom.
                        if (ny[10]) begin
                            ball_y_reg <= 10'd0;
                            vy_reg     <= -vy_post;
                        end else if (!hit_now && (ny > Y_MAX_S)) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            ball_y_reg <= ny[9:0];
                            vy_reg     <= vy_post;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ball_x   = ball_x_reg;
    assign ball_y   = ball_y_reg;
    assign state    = state_reg;
    assign score    = score_reg;
    assign hit_flag = hit_flag_reg;

endmodule

// File: tb/tb_ball_game_controller.sv
// Directed bench for ball_game_controller: serve timing, wall and ceiling
// bounces, hit threshold/discard/saturation, game over and async reset.
module tb_ball_game_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       pixel_valid;
    logic       is_hit_area;
    logic       obj_pixel;
    logic       start_btn;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [1:0] state;
    logic [7:0] score;
    logic       hit_flag;

    int vectors     = 0;
    int miscompares = 0;

    ball_game_controller dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .pixel_valid (pixel_valid),
        .is_hit_area (is_hit_area),
        .obj_pixel   (obj_pixel),
        .start_btn   (start_btn),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .state       (state),
        .score       (score),
        .hit_flag    (hit_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int st);
        chk({tag, ".x"}, 32'(ball_x), 32'(x));
        chk({tag, ".y"}, 32'(ball_y), 32'(y));
        chk({tag, ".state"}, 32'(state), 32'(st));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            step();
        end
    endtask

    task automatic pix(input int n);
        pixel_valid = 1'b1; is_hit_area = 1'b1; obj_pixel = 1'b1;
        repeat (n) step();
        pixel_valid = 1'b0; is_hit_area = 1'b0; obj_pixel = 1'b0;
    endtask

    // Pixels missing exactly one of the three qualifiers; none may count.
    task automatic near_pix(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_valid = (i % 3) != 0;
            is_hit_area = (i % 3) != 1;
            obj_pixel   = (i % 3) != 2;
            step();
        end
        pixel_valid = 1'b0; is_hit_area = 1'b0; obj_pixel = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_pos(tag, 310, 230, 0);
        chk({tag, ".score"}, 32'(score), 32'd0);
        chk({tag, ".hit_flag"}, 32'(hit_flag), 32'd0);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0;
        pixel_valid = 1'b0; is_hit_area = 1'b0; obj_pixel = 1'b0;
        step(); step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step();

        // Idle ignores frame ticks.
        tick();
        chk_pos("idle_tick", 310, 230, 0);
        step();

        // Start edge coincident with a frame tick: that tick is not a serve tick.
        start_btn = 1'b1; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("start_edge.state", 32'(state), 32'd1);
        ticks(30);
        start_btn = 1'b0; step();
        start_btn = 1'b1; step();
        chk("serve_ignores_start", 32'(state), 32'd1);
        ticks(29);
        chk_pos("serve_59", 310, 230, 1);
        tick();
        chk_pos("serve_60", 310, 230, 2);
        step();

        // First serve: vx=-2, vy=+2.
        tick();
        chk_pos("play_first", 308, 232, 2);
        step();
        ticks(99);
        chk_pos("play_k100", 110, 430, 2);

        // 39 pixels plus one in the tick cycle: no hit.
        pix(39);
        pixel_valid = 1'b1; is_hit_area = 1'b1; obj_pixel = 1'b1;
        tick();
        pixel_valid = 1'b0; is_hit_area = 1'b0; obj_pixel = 1'b0;
        chk_pos("tick_pixel_dropped", 108, 432, 2);
        chk("tick_pixel_dropped.score", 32'(score), 32'd0);
        chk("tick_pixel_dropped.hit_flag", 32'(hit_flag), 32'd0);
        step();

        pix(39);
        near_pix(30);
        tick();
        chk_pos("thresh_39", 106, 434, 2);
        chk("thresh_39.score", 32'(score), 32'd0);
        step();

        // Exactly 40 pixels: bounce to vy=-3.
        pix(40);
        tick();
        chk_pos("hit_40", 104, 431, 2);
        chk("hit_40.score", 32'(score), 32'd1);
        chk("hit_40.hit_flag", 32'(hit_flag), 32'd1);
        step();
        chk("hit_40.flag_drop", 32'(hit_flag), 32'd0);

        // Moving up: pixels do not score.
        pix(40);
        tick();
        chk_pos("vy_neg_no_hit", 102, 428, 2);
        chk("vy_neg_no_hit.score", 32'(score), 32'd1);
        chk("vy_neg_no_hit.hit_flag", 32'(hit_flag), 32'd0);
        step();

        // Left wall.
        ticks(51);
        chk_pos("left_at_0", 0, 275, 2);
        ticks(1);
        chk_pos("left_clamp", 0, 272, 2);
        ticks(1);
        chk_pos("left_after", 2, 269, 2);

        // Ceiling.
        ticks(89);
        chk_pos("top_before", 180, 2, 2);
        ticks(1);
        chk_pos("top_clamp", 182, 0, 2);
        ticks(1);
        chk_pos("top_after", 184, 3, 2);
        ticks(99);
        chk_pos("pre_sat", 382, 300, 2);

        // 532 pixels: counter must saturate, one hit, vy=-4.
        pix(532);
        tick();
        chk_pos("sat_hit", 384, 296, 2);
        chk("sat_hit.score", 32'(score), 32'd2);
        chk("sat_hit.hit_flag", 32'(hit_flag), 32'd1);
        step();
        chk("sat_hit.flag_drop", 32'(hit_flag), 32'd0);

        ticks(74);
        chk_pos("top2_at_0", 532, 0, 2);
        ticks(1);
        chk_pos("top2_clamp", 534, 0, 2);
        ticks(1);
        chk_pos("top2_after", 536, 4, 2);

        // Right wall.
        ticks(41);
        chk_pos("right_before", 618, 168, 2);
        ticks(1);
        chk_pos("right_at_620", 620, 172, 2);
        ticks(1);
        chk_pos("right_clamp", 620, 176, 2);
        ticks(1);
        chk_pos("right_after", 618, 180, 2);

        // Bottom: y=460 is still in play, the next tick ends the game.
        ticks(70);
        chk_pos("bottom_edge", 478, 460, 2);
        ticks(1);
        chk_pos("game_over", 476, 460, 0);
        chk("game_over.score", 32'(score), 32'd2);

        // Game over held while start is still high and frames continue.
        pix(50);
        ticks(4);
        chk_pos("over_held", 476, 460, 0);
        chk("over_held.score", 32'(score), 32'd2);
        chk("over_held.hit_flag", 32'(hit_flag), 32'd0);

        // Second serve goes right.
        start_btn = 1'b0; step();
        start_btn = 1'b1; step();
        chk_pos("serve2", 310, 230, 1);
        chk("serve2.score", 32'(score), 32'd0);
        ticks(60);
        chk("serve2_play", 32'(state), 32'd2);
        ticks(1);
        chk_pos("serve2_first", 312, 232, 2);
        pix(40);
        tick();
        chk_pos("serve2_hit", 314, 229, 2);
        chk("serve2_hit.score", 32'(score), 32'd1);
        chk("serve2_hit.hit_flag", 32'(hit_flag), 32'd1);

        // Asynchronous reset mid-cycle.
        #2;
        reset = 1'b1; start_btn = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        step();
        reset = 1'b0;
        step();

        // Serve direction restarts as negative after reset.
        start_btn = 1'b1; step();
        chk("serve3.state", 32'(state), 32'd1);
        ticks(60);
        ticks(1);
        chk_pos("serve3_first", 308, 232, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
